// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master (I fetch, D data) to one-slave arbiter with watchdog; define POLARIS_ARB_RR_EN for round-robin ties
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [1:0]  i_siz_i,
    input  logic [63:0] i_adr_i,
    output logic        i_ack_o,
    output logic        i_err_o,
    output logic [31:0] i_dat_o,
    input  logic [1:0]  d_siz_i,
    input  logic [63:0] d_adr_i,
    input  logic        d_we_i,
    input  logic [63:0] d_dat_i,
    output logic        d_ack_o,
    output logic        d_err_o,
    output logic [63:0] d_dat_o,
    output logic [1:0]  m_siz_o,
    output logic [63:0] m_adr_o,
    output logic        m_we_o,
    output logic [63:0] m_dat_o,
    input  logic        m_ack_i,
    input  logic [63:0] m_dat_i,
    output logic [1:0]  gnt_o
);
    typedef enum logic [1:0] {IDLE = 2'b00, GNT_I = 2'b01, GNT_D = 2'b10} state_t;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    state_t      r_state;
    logic [15:0] r_cnt;
    logic        w_i_req;
    logic        w_d_req;
    logic        w_d_win;
    logic        w_tmo;
    assign w_i_req = |i_siz_i;
    assign w_d_req = |d_siz_i;
    assign w_tmo   = (TIMEOUT != 0) && (r_state != IDLE) && (r_cnt == TMO_LAST) && !m_ack_i;
    assign gnt_o   = r_state;
`ifdef POLARIS_ARB_RR_EN
    logic r_last_d;
    assign w_d_win = w_d_req & (~w_i_req | ~r_last_d);
    // remember who won the last grant so a tie goes to the other master
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            r_last_d <= 1'b1;
        else if (r_state == IDLE && (w_i_req || w_d_req))
            r_last_d <= w_d_win;
    end
`else
    assign w_d_win = w_d_req;
`endif
    // grant FSM with watchdog; counter is held at zero in IDLE so it starts clean on every grant
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_d_win)
                        r_state <= GNT_D;
                    else if (w_i_req)
                        r_state <= GNT_I;
                end
                GNT_I, GNT_D: begin
                    if (m_ack_i || w_tmo)
                        r_state <= IDLE;
                    else
                        r_cnt <= r_cnt + 16'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    // combinational routing between the granted master and the slave; everything else reads 0
    always_comb begin
        m_siz_o = 2'b00;
        m_adr_o = '0;
        m_we_o  = 1'b0;
        m_dat_o = '0;
        i_ack_o = 1'b0;
        i_err_o = 1'b0;
        i_dat_o = '0;
        d_ack_o = 1'b0;
        d_err_o = 1'b0;
        d_dat_o = '0;
        if (r_state == GNT_I) begin
            m_siz_o = i_siz_i;
            m_adr_o = i_adr_i;
            i_ack_o = m_ack_i;
            i_err_o = w_tmo;
            i_dat_o = m_dat_i[31:0];
        end else if (r_state == GNT_D) begin
            m_siz_o = d_siz_i;
            m_adr_o = d_adr_i;
            m_we_o  = d_we_i;
            m_dat_o = d_dat_i;
            d_ack_o = m_ack_i;
            d_err_o = w_tmo;
            d_dat_o = m_dat_i;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter (TIMEOUT=4)
module tb_bus_arbiter;
    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [1:0]  i_siz_i = '0;
    logic [63:0] i_adr_i = '0;
    logic        i_ack_o;
    logic        i_err_o;
    logic [31:0] i_dat_o;
    logic [1:0]  d_siz_i = '0;
    logic [63:0] d_adr_i = '0;
    logic        d_we_i = 1'b0;
    logic [63:0] d_dat_i = '0;
    logic        d_ack_o;
    logic        d_err_o;
    logic [63:0] d_dat_o;
    logic [1:0]  m_siz_o;
    logic [63:0] m_adr_o;
    logic        m_we_o;
    logic [63:0] m_dat_o;
    logic        m_ack_i = 1'b0;
    logic [63:0] m_dat_i = '0;
    logic [1:0]  gnt_o;
    int checks = 0;
    int errors = 0;

    bus_arbiter #(.TIMEOUT(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .i_siz_i(i_siz_i), .i_adr_i(i_adr_i), .i_ack_o(i_ack_o), .i_err_o(i_err_o), .i_dat_o(i_dat_o),
        .d_siz_i(d_siz_i), .d_adr_i(d_adr_i), .d_we_i(d_we_i), .d_dat_i(d_dat_i),
        .d_ack_o(d_ack_o), .d_err_o(d_err_o), .d_dat_o(d_dat_o),
        .m_siz_o(m_siz_o), .m_adr_o(m_adr_o), .m_we_o(m_we_o), .m_dat_o(m_dat_o),
        .m_ack_i(m_ack_i), .m_dat_i(m_dat_i), .gnt_o(gnt_o)
    );

    always #5 clk_i = ~clk_i;

    task nxt;
        @(posedge clk_i);
        #1;
    endtask

    task test_reset;
        i_siz_i = 2'b10; d_siz_i = 2'b01; d_we_i = 1'b1; d_dat_i = 64'h1111; m_ack_i = 1'b1; m_dat_i = 64'hFFFF_FFFF_FFFF_FFFF;
        #22;
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b exp 00", gnt_o); end
        checks++; if (m_siz_o !== 2'b00 || m_adr_o !== 64'h0 || m_we_o !== 1'b0 || m_dat_o !== 64'h0) begin errors++; $display("FAIL rst_m: siz %b adr %h we %b dat %h exp all 0", m_siz_o, m_adr_o, m_we_o, m_dat_o); end
        checks++; if ({i_ack_o, i_err_o, d_ack_o, d_err_o} !== 4'b0) begin errors++; $display("FAIL rst_ackerr: got %b exp 0000", {i_ack_o, i_err_o, d_ack_o, d_err_o}); end
        checks++; if (i_dat_o !== 32'h0 || d_dat_o !== 64'h0) begin errors++; $display("FAIL rst_dat: i %h d %h exp 0", i_dat_o, d_dat_o); end
        @(negedge clk_i);
        reset_i = 1'b0; d_siz_i = 2'b00; d_we_i = 1'b0; m_ack_i = 1'b0; m_dat_i = '0; i_adr_i = 64'hFFFF_FFFF_FFFF_FF00;
        nxt;
        checks++; if (m_siz_o !== 2'b10) begin errors++; $display("FAIL rst_rel_siz: got %b exp 10", m_siz_o); end
        checks++; if (m_adr_o !== 64'hFFFF_FFFF_FFFF_FF00) begin errors++; $display("FAIL rst_rel_adr: got %h exp ffffffffffffff00", m_adr_o); end
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rst_rel_gnt: got %b exp 01", gnt_o); end
        m_ack_i = 1'b1;
        #1;
        checks++; if (i_ack_o !== 1'b1) begin errors++; $display("FAIL rst_rel_ack: got %b exp 1", i_ack_o); end
        nxt;
        i_siz_i = 2'b00; m_ack_i = 1'b0;
    endtask

    task test_read_return;
        i_siz_i = 2'b01; i_adr_i = 64'h1000;
        nxt;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rd_gnt: got %b exp 01", gnt_o); end
        nxt;
        nxt;
        checks++; if (i_ack_o !== 1'b0) begin errors++; $display("FAIL rd_noack: got %b exp 0", i_ack_o); end
        nxt;
        m_ack_i = 1'b1; m_dat_i = 64'h0000_0000_0000_0013;
        #1;
        checks++; if (i_ack_o !== 1'b1 || i_dat_o !== 32'h13) begin errors++; $display("FAIL rd_ack: ack %b dat %h exp 1 00000013", i_ack_o, i_dat_o); end
        checks++; if (i_err_o !== 1'b0 || d_ack_o !== 1'b0 || d_dat_o !== 64'h0) begin errors++; $display("FAIL rd_other: ierr %b dack %b ddat %h exp 0", i_err_o, d_ack_o, d_dat_o); end
        nxt;
        i_siz_i = 2'b00;
        #1;
        checks++; if (m_siz_o !== 2'b00 || gnt_o !== 2'b00) begin errors++; $display("FAIL rd_idle: siz %b gnt %b exp 00 00", m_siz_o, gnt_o); end
        checks++; if (i_ack_o !== 1'b0 || i_dat_o !== 32'h0) begin errors++; $display("FAIL rd_once: ack %b dat %h exp 0", i_ack_o, i_dat_o); end
        m_ack_i = 1'b0; m_dat_i = '0;
    endtask

    task test_tie;
        i_siz_i = 2'b10; i_adr_i = 64'h3000;
        d_siz_i = 2'b11; d_adr_i = 64'h2000; d_we_i = 1'b1; d_dat_i = 64'hDEAD_BEEF;
        nxt;
        checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL tie_gnt: got %b exp 10", gnt_o); end
        checks++; if (m_we_o !== 1'b1 || m_dat_o !== 64'hDEAD_BEEF) begin errors++; $display("FAIL tie_wr: we %b dat %h exp 1 deadbeef", m_we_o, m_dat_o); end
        checks++; if (m_siz_o !== 2'b11 || m_adr_o !== 64'h2000) begin errors++; $display("FAIL tie_adr: siz %b adr %h exp 11 2000", m_siz_o, m_adr_o); end
        m_ack_i = 1'b1; m_dat_i = 64'hAAAA_5555_1234_5678;
        #1;
        checks++; if (d_ack_o !== 1'b1 || d_dat_o !== 64'hAAAA_5555_1234_5678) begin errors++; $display("FAIL tie_dack: ack %b dat %h exp 1 aaaa555512345678", d_ack_o, d_dat_o); end
        checks++; if (i_ack_o !== 1'b0 || i_dat_o !== 32'h0) begin errors++; $display("FAIL tie_iquiet: ack %b dat %h exp 0", i_ack_o, i_dat_o); end
        nxt;
        d_siz_i = 2'b00; d_we_i = 1'b0; m_ack_i = 1'b0;
        #1;
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL tie_idle: got %b exp 00", gnt_o); end
        nxt;
        checks++; if (gnt_o !== 2'b01 || m_we_o !== 1'b0 || m_dat_o !== 64'h0) begin errors++; $display("FAIL tie_igr: gnt %b we %b dat %h exp 01 0 0", gnt_o, m_we_o, m_dat_o); end
        m_ack_i = 1'b1;
        #1;
        checks++; if (i_ack_o !== 1'b1) begin errors++; $display("FAIL tie_iack: got %b exp 1", i_ack_o); end
        nxt;
        i_siz_i = 2'b00; m_ack_i = 1'b0; m_dat_i = '0;
    endtask

    task test_back_to_back;
        logic [1:0] exp_g;
        i_siz_i = 2'b01; d_siz_i = 2'b01; m_ack_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            nxt;
`ifdef POLARIS_ARB_RR_EN
            exp_g = (k % 2 == 1) ? 2'b00 : (((k / 2) % 2 == 0) ? 2'b10 : 2'b01);
`else
            exp_g = (k % 2 == 1) ? 2'b00 : 2'b10;
`endif
            checks++; if (gnt_o !== exp_g) begin errors++; $display("FAIL b2b_gnt%0d: got %b exp %b", k, gnt_o, exp_g); end
        end
        i_siz_i = 2'b00; d_siz_i = 2'b00; m_ack_i = 1'b0;
    endtask

    task test_watchdog;
        d_siz_i = 2'b10; d_adr_i = 64'h4000;
        nxt;
        nxt;
        nxt;
        checks++; if (d_err_o !== 1'b0 || gnt_o !== 2'b10) begin errors++; $display("FAIL wd_early: err %b gnt %b exp 0 10", d_err_o, gnt_o); end
        nxt;
        checks++; if (d_err_o !== 1'b1 || d_ack_o !== 1'b0) begin errors++; $display("FAIL wd_err: err %b ack %b exp 1 0", d_err_o, d_ack_o); end
        checks++; if (i_err_o !== 1'b0) begin errors++; $display("FAIL wd_ierr: got %b exp 0", i_err_o); end
        nxt;
        checks++; if (gnt_o !== 2'b00 || d_err_o !== 1'b0) begin errors++; $display("FAIL wd_idle: gnt %b err %b exp 00 0", gnt_o, d_err_o); end
        nxt;
        nxt;
        nxt;
        nxt;
        m_ack_i = 1'b1;
        #1;
        checks++; if (d_ack_o !== 1'b1 || d_err_o !== 1'b0) begin errors++; $display("FAIL wd_ackwins: ack %b err %b exp 1 0", d_ack_o, d_err_o); end
        nxt;
        d_siz_i = 2'b00; m_ack_i = 1'b0;
    endtask

    task test_early_drop;
        i_siz_i = 2'b11; i_adr_i = 64'h5000;
        nxt;
        i_siz_i = 2'b00;
        #1;
        checks++; if (m_siz_o !== 2'b00 || gnt_o !== 2'b01) begin errors++; $display("FAIL drop_siz: siz %b gnt %b exp 00 01", m_siz_o, gnt_o); end
        nxt;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL drop_hold: got %b exp 01", gnt_o); end
        m_ack_i = 1'b1;
        #1;
        checks++; if (i_ack_o !== 1'b1) begin errors++; $display("FAIL drop_ack: got %b exp 1", i_ack_o); end
        nxt;
        m_ack_i = 1'b0;
        #1;
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL drop_idle: got %b exp 00", gnt_o); end
    endtask

    task test_reset_mid_grant;
        d_siz_i = 2'b01; d_adr_i = 64'h6000;
        nxt;
        i_siz_i = 2'b01; m_ack_i = 1'b1;
        #1;
        checks++; if (gnt_o !== 2'b10 || d_ack_o !== 1'b1) begin errors++; $display("FAIL rmg_pre: gnt %b ack %b exp 10 1", gnt_o, d_ack_o); end
        reset_i = 1'b1;
        #1;
        checks++; if (m_siz_o !== 2'b00 || gnt_o !== 2'b00 || d_ack_o !== 1'b0) begin errors++; $display("FAIL rmg_async: siz %b gnt %b ack %b exp 00 00 0", m_siz_o, gnt_o, d_ack_o); end
        @(negedge clk_i);
        reset_i = 1'b0; d_siz_i = 2'b00; m_ack_i = 1'b0;
        nxt;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rmg_igr: got %b exp 01", gnt_o); end
        m_ack_i = 1'b1;
        nxt;
        i_siz_i = 2'b00; m_ack_i = 1'b0;
    endtask

    initial begin
        test_reset;
        test_read_return;
        test_tie;
        test_back_to_back;
        test_watchdog;
        test_early_drop;
        test_reset_mid_grant;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
